// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - two-entry fetch/decode pipeline register with registered in_ready
// Optional performance counters are enabled with `define IF_ID_PERF_CNT_EN.
module if_id_skid_reg #(
    parameter int                 INSTR_W   = 16,
    parameter int                 PC_W      = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               hold,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [PC_W-1:0]    in_pc_plus_1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_pc_plus_1
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        flush_cnt
`endif
);

    localparam int E_W = INSTR_W + 2 * PC_W;
    localparam logic [E_W-1:0] ENTRY_NOP = {NOP_INSTR, {PC_W{1'b0}}, {PC_W{1'b0}}};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [E_W-1:0] main_q, main_n;
    logic [E_W-1:0] skid_q, skid_n;
    logic           in_ready_q, in_ready_n;
    logic [E_W-1:0] in_entry;
    logic           acc, xfer;

    assign in_entry  = {in_instr, in_pc, in_pc_plus_1};
    assign in_ready  = in_ready_q;
    assign out_valid = (state != EMPTY);
    assign acc       = in_valid & in_ready_q;
    assign xfer      = out_valid & out_ready & ~hold;

    assign {out_instr, out_pc, out_pc_plus_1} = main_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            main_q     <= ENTRY_NOP;
            skid_q     <= ENTRY_NOP;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_n;
            main_q     <= main_n;
            skid_q     <= skid_n;
            in_ready_q <= in_ready_n;
        end
    end

    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            // Flush wins over everything; an input offered this cycle is dropped.
            state_n = EMPTY;
            main_n  = ENTRY_NOP;
            skid_n  = ENTRY_NOP;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        main_n  = in_entry;
                        state_n = ONE;
                    end
                end
                ONE: begin
                    if (acc && xfer) begin
                        main_n = in_entry;
                    end else if (acc) begin
                        skid_n  = in_entry;
                        state_n = TWO;
                    end else if (xfer) begin
                        main_n  = ENTRY_NOP;
                        state_n = EMPTY;
                    end
                end
                TWO: begin
                    if (xfer) begin
                        main_n  = skid_q;
                        skid_n  = ENTRY_NOP;
                        state_n = ONE;
                    end
                end
                default: begin
                    state_n = EMPTY;
                    main_n  = ENTRY_NOP;
                    skid_n  = ENTRY_NOP;
                end
            endcase
        end
        // Ready is a flop: it looks ahead at whether the skid slot will be free.
        in_ready_n = (state_n != TWO);
    end

`ifdef IF_ID_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !xfer && !flush && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (flush && out_valid && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule
